cla_reg_adder: RTL and testbench

- Parameterised unsigned binary adder computing add1 + add0 + carry_in.
- Built as a 4-bit-group carry-lookahead structure, with a single registered output stage.
- Serves as the shared add/subtract datapath primitive of the multiply/division unit.
- Produces the sum, the carry-out, and status flags one clock after the inputs are accepted.

---
 rtl/cla_reg_adder.sv | 101 ++++++++++
 tb/tb_cla_reg_adder.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_reg_adder.sv
// Registered carry-lookahead adder: {carry_out, sum} = add1 + add0 + carry_in,
// built from 4-bit lookahead groups with the group carries rippled between them.
module cla_reg_adder #(
  parameter int parallelism = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [parallelism-1:0] add1,
  input  logic [parallelism-1:0] add0,
  input  logic                   carry_in,
  output logic [parallelism-1:0] sum,
  output logic                   carry_out,
  output logic                   overflow,
  output logic                   zero,
  output logic                   out_valid
);

  localparam int NG = (parallelism + 3) / 4;

  logic [parallelism-1:0] sum_nxt;
  logic                   cout_nxt;
  logic                   msb_cin;

  for (genvar k = 0; k < NG; k++) begin : grp
    localparam int LO = 4 * k;
    // The last group is narrower when the width is not a multiple of 4.
    localparam int GW = (parallelism - LO < 4) ? (parallelism - LO) : 4;

    logic [GW-1:0] g;
    logic [GW-1:0] p;
    logic [GW-1:0] c;
    logic          cin;
    logic          grp_g;
    logic          grp_p;
    logic          cout;

    assign g = add1[LO +: GW] & add0[LO +: GW];
    assign p = add1[LO +: GW] ^ add0[LO +: GW];

    if (k == 0) begin : first
      assign cin = carry_in;
    end else begin : chain
      assign cin = grp[k-1].cout;
    end

    // Each carry is a flat sum of products over the group's g/p terms.
    always_comb begin
      logic term;
      c     = '0;
      grp_g = 1'b0;
      grp_p = 1'b1;
      term  = 1'b0;
      for (int i = 0; i < GW; i++) begin
        term = cin;
        for (int m = 0; m < i; m++) term = term & p[m];
        c[i] = term;
        for (int j = 0; j < i; j++) begin
          term = g[j];
          for (int m = j + 1; m < i; m++) term = term & p[m];
          c[i] = c[i] | term;
        end
      end
      for (int j = 0; j < GW; j++) begin
        term = g[j];
        for (int m = j + 1; m < GW; m++) term = term & p[m];
        grp_g = grp_g | term;
        grp_p = grp_p & p[j];
      end
    end

    assign cout = grp_g | (grp_p & cin);
    assign sum_nxt[LO +: GW] = p ^ c;

    if (k == NG - 1) begin : msb
      assign msb_cin  = c[GW-1];
      assign cout_nxt = cout;
    end
  end

  // in_valid=1 at an edge loads a result and raises out_valid for one cycle;
  // in_valid=0 drops out_valid and holds the data. No backpressure exists.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum       <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
      out_valid <= 1'b0;
    end else if (in_valid) begin
      sum       <= sum_nxt;
      carry_out <= cout_nxt;
      overflow  <= msb_cin ^ cout_nxt;
      zero      <= ~|sum_nxt;
      out_valid <= 1'b1;
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cla_reg_adder.sv
// Bench for cla_reg_adder: four instances (widths 1, 4, 7, 16) driven together
// and checked against an integer-arithmetic reference model.
module tb_cla_reg_adder;

  localparam int NL = 4;
  int wid[NL] = '{1, 4, 7, 16};

  logic clk = 1'b0;
  logic rst;
  logic in_valid;
  logic [15:0] a1[NL];
  logic [15:0] a0[NL];
  logic        cin[NL];

  logic [0:0]  s1;
  logic [3:0]  s4;
  logic [6:0]  s7;
  logic [15:0] s16;
  logic [15:0] s_o[NL];
  logic        c_o[NL];
  logic        o_o[NL];
  logic        z_o[NL];
  logic        v_o[NL];

  logic [15:0] e_sum[NL];
  logic        e_c[NL];
  logic        e_o[NL];
  logic        e_z[NL];
  logic        e_v;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  assign s_o[0] = 16'(s1);
  assign s_o[1] = 16'(s4);
  assign s_o[2] = 16'(s7);
  assign s_o[3] = s16;

  cla_reg_adder #(.parallelism(1)) u_w1 (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .add1(a1[0][0:0]), .add0(a0[0][0:0]), .carry_in(cin[0]),
    .sum(s1), .carry_out(c_o[0]), .overflow(o_o[0]), .zero(z_o[0]), .out_valid(v_o[0])
  );
  cla_reg_adder #(.parallelism(4)) u_w4 (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .add1(a1[1][3:0]), .add0(a0[1][3:0]), .carry_in(cin[1]),
    .sum(s4), .carry_out(c_o[1]), .overflow(o_o[1]), .zero(z_o[1]), .out_valid(v_o[1])
  );
  cla_reg_adder #(.parallelism(7)) u_w7 (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .add1(a1[2][6:0]), .add0(a0[2][6:0]), .carry_in(cin[2]),
    .sum(s7), .carry_out(c_o[2]), .overflow(o_o[2]), .zero(z_o[2]), .out_valid(v_o[2])
  );
  cla_reg_adder #(.parallelism(16)) u_w16 (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .add1(a1[3]), .add0(a0[3]), .carry_in(cin[3]),
    .sum(s16), .carry_out(c_o[3]), .overflow(o_o[3]), .zero(z_o[3]), .out_valid(v_o[3])
  );

  function automatic logic [15:0] mask_of(input int w);
    logic [16:0] m;
    m = (17'd1 << w) - 17'd1;
    return m[15:0];
  endfunction

  task automatic set_random(input int i);
    a1[i]  = 16'($urandom) & mask_of(wid[i]);
    a0[i]  = 16'($urandom) & mask_of(wid[i]);
    cin[i] = 1'($urandom);
  endtask

  // Reference: exact unsigned sum for carry/sum, signed range test for overflow.
  task automatic cycle(input logic v, input logic r);
    longint ua, ub, tot, full, half, sa, sb, st;
    rst      = r;
    in_valid = v;
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < NL; i++) begin
        e_sum[i] = '0; e_c[i] = 1'b0; e_o[i] = 1'b0; e_z[i] = 1'b0;
      end
      e_v = 1'b0;
    end else if (v) begin
      for (int i = 0; i < NL; i++) begin
        full = longint'(1) << wid[i];
        half = full >> 1;
        ua = longint'(a1[i] & mask_of(wid[i]));
        ub = longint'(a0[i] & mask_of(wid[i]));
        tot = ua + ub + longint'(cin[i]);
        e_sum[i] = 16'(tot % full);
        e_c[i]   = (tot >= full);
        sa = (ua >= half) ? ua - full : ua;
        sb = (ub >= half) ? ub - full : ub;
        st = sa + sb + longint'(cin[i]);
        e_o[i] = (st < -half) || (st >= half);
        e_z[i] = (e_sum[i] == 16'd0);
      end
      e_v = 1'b1;
    end else begin
      e_v = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < NL; i++) set_random(i);
    cycle(1'b1, 1'b1);
    for (int i = 0; i < NL; i++) begin
      checks++;
      if ({s_o[i], c_o[i], o_o[i], z_o[i], v_o[i]} !== 20'd0) begin
        fails++;
        $display("FAIL reset w=%0d: got sum=%h c=%b o=%b z=%b v=%b, want all zero",
                 wid[i], s_o[i], c_o[i], o_o[i], z_o[i], v_o[i]);
      end
    end
  endtask

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       ci;
    logic [3:0] s;
    logic       co;
    logic       ov;
    logic       z;
  } vec_t;

  task automatic test_directed();
    vec_t vt[6] = '{
      '{4'b0010, 4'b0011, 1'b0, 4'b0101, 1'b0, 1'b0, 1'b0},
      '{4'b1101, 4'b0011, 1'b1, 4'b0001, 1'b1, 1'b0, 1'b0},
      '{4'b1101, 4'b0011, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b1},
      '{4'b1111, 4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b1},
      '{4'b0111, 4'b0001, 1'b0, 4'b1000, 1'b0, 1'b1, 1'b0},
      '{4'b1000, 4'b1000, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b1}
    };
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < NL; i++) begin
        a1[i]  = 16'(vt[t].a) & mask_of(wid[i]);
        a0[i]  = 16'(vt[t].b) & mask_of(wid[i]);
        cin[i] = vt[t].ci;
      end
      cycle(1'b1, 1'b0);
      checks++;
      if ({s4, c_o[1], o_o[1], z_o[1], v_o[1]} !== {vt[t].s, vt[t].co, vt[t].ov, vt[t].z, 1'b1}) begin
        fails++;
        $display("FAIL directed%0d: got sum=%b c=%b o=%b z=%b v=%b, want sum=%b c=%b o=%b z=%b v=1",
                 t, s4, c_o[1], o_o[1], z_o[1], v_o[1], vt[t].s, vt[t].co, vt[t].ov, vt[t].z);
      end
      for (int i = 0; i < NL; i++) begin
        checks++;
        if ({s_o[i], c_o[i], o_o[i], z_o[i], v_o[i]} !== {e_sum[i], e_c[i], e_o[i], e_z[i], e_v}) begin
          fails++;
          $display("FAIL directed_model%0d w=%0d: got %h/%b%b%b%b want %h/%b%b%b%b", t, wid[i],
                   s_o[i], c_o[i], o_o[i], z_o[i], v_o[i], e_sum[i], e_c[i], e_o[i], e_z[i], e_v);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 4; n++) begin
      for (int i = 0; i < NL; i++) set_random(i);
      cycle(n < 3, 1'b0);
      for (int i = 0; i < NL; i++) begin
        checks++;
        if ({s_o[i], c_o[i], o_o[i], z_o[i], v_o[i]} !== {e_sum[i], e_c[i], e_o[i], e_z[i], e_v}) begin
          fails++;
          $display("FAIL back_to_back%0d w=%0d: got %h/%b%b%b%b want %h/%b%b%b%b", n, wid[i],
                   s_o[i], c_o[i], o_o[i], z_o[i], v_o[i], e_sum[i], e_c[i], e_o[i], e_z[i], e_v);
        end
      end
    end
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < NL; i++) begin
      a1[i] = mask_of(wid[i]); a0[i] = 16'd1; cin[i] = 1'b1;
    end
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b1);
    for (int i = 0; i < NL; i++) begin
      checks++;
      if ({s_o[i], c_o[i], o_o[i], z_o[i], v_o[i]} !== 20'd0) begin
        fails++;
        $display("FAIL reset_midstream w=%0d: got sum=%h c=%b o=%b z=%b v=%b, want all zero",
                 wid[i], s_o[i], c_o[i], o_o[i], z_o[i], v_o[i]);
      end
    end
  endtask

  task automatic test_exhaustive();
    for (int x = 0; x < 512; x++) begin
      a1[0] = 16'(x & 1);         a0[0] = 16'((x >> 1) & 1);  cin[0] = 1'((x >> 2) & 1);
      a1[1] = 16'(x & 15);        a0[1] = 16'((x >> 4) & 15); cin[1] = 1'((x >> 8) & 1);
      set_random(2);
      set_random(3);
      cycle(1'b1, 1'b0);
      for (int i = 0; i < NL; i++) begin
        checks++;
        if ({s_o[i], c_o[i], o_o[i], z_o[i], v_o[i]} !== {e_sum[i], e_c[i], e_o[i], e_z[i], e_v}) begin
          fails++;
          $display("FAIL exhaustive x=%0d w=%0d: got %h/%b%b%b%b want %h/%b%b%b%b", x, wid[i],
                   s_o[i], c_o[i], o_o[i], z_o[i], v_o[i], e_sum[i], e_c[i], e_o[i], e_z[i], e_v);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 10000; n++) begin
      for (int i = 0; i < NL; i++) begin
        if (n == 0) begin
          a1[i] = mask_of(wid[i]); a0[i] = mask_of(wid[i]); cin[i] = 1'b1;
        end else begin
          set_random(i);
        end
      end
      cycle((n == 0) || ($urandom_range(0, 4) != 0), (n != 0) && ($urandom_range(0, 99) == 0));
      for (int i = 0; i < NL; i++) begin
        checks++;
        if ({s_o[i], c_o[i], o_o[i], z_o[i], v_o[i]} !== {e_sum[i], e_c[i], e_o[i], e_z[i], e_v}) begin
          fails++;
          $display("FAIL random n=%0d w=%0d: got %h/%b%b%b%b want %h/%b%b%b%b", n, wid[i],
                   s_o[i], c_o[i], o_o[i], z_o[i], v_o[i], e_sum[i], e_c[i], e_o[i], e_z[i], e_v);
        end
      end
    end
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    for (int i = 0; i < NL; i++) begin
      a1[i] = '0; a0[i] = '0; cin[i] = 1'b0;
      e_sum[i] = '0; e_c[i] = 1'b0; e_o[i] = 1'b0; e_z[i] = 1'b0;
    end
    e_v = 1'b0;
    cycle(1'b0, 1'b1);
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_midstream();
    test_exhaustive();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
